// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: FSM state encoding and the
// counter-width helper used to size every internal counter.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_RPT  = 2'd2
    } key_state_t;

    // Bits needed to hold the largest of the three cycle counts without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle of the key conditioner's data-side signals: raw key in, debounced
// level and event pulses out.
interface key_conditioner_if;
    logic d_i;
    logic d_o;
    logic p_press;
    logic p_rel;
    logic p_long;
    logic p_rpt;

    modport master (output d_i, input d_o, p_press, p_rel, p_long, p_rpt);
    modport slave  (input d_i, output d_o, p_press, p_rel, p_long, p_rpt);
endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous raw key level.
module key_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/key_conditioner.sv
// Debounces a raw key and emits press, release, long-press and auto-repeat
// pulses; all outputs are registered.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned CN = 240000,
    parameter int unsigned LN = 24000000,
    parameter int unsigned RN = 4800000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic d_o,
    output logic p_press,
    output logic p_rel,
    output logic p_long,
    output logic p_rpt
);
    localparam int unsigned W = cnt_width(CN, LN, RN);
    localparam logic [W-1:0] CN_M1 = W'(CN - 1);
    localparam logic [W-1:0] LN_M1 = W'(LN - 1);
    localparam logic [W-1:0] LN_W  = W'(LN);
    localparam logic [W-1:0] RN_M1 = W'(RN - 1);

    logic s;
    key_state_t state, state_nx;
    logic [W-1:0] deb_cnt, deb_nx;
    logic [W-1:0] hold_cnt, hold_nx;
    logic [W-1:0] rpt_cnt, rpt_nx;
    logic press_nx, rel_nx, long_nx, rpt_p_nx;

    key_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d_i),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            rpt_cnt  <= '0;
            d_o      <= 1'b0;
            p_press  <= 1'b0;
            p_rel    <= 1'b0;
            p_long   <= 1'b0;
            p_rpt    <= 1'b0;
        end else begin
            state    <= state_nx;
            deb_cnt  <= deb_nx;
            hold_cnt <= hold_nx;
            rpt_cnt  <= rpt_nx;
            d_o      <= (state_nx != ST_IDLE);
            p_press  <= press_nx;
            p_rel    <= rel_nx;
            p_long   <= long_nx;
            p_rpt    <= rpt_p_nx;
        end
    end

    // Release only happens on s=0 edges, while hold/repeat counters only move on
    // s=1 edges, so a release can never coincide with another pulse.
    always_comb begin
        state_nx = state;
        deb_nx   = deb_cnt;
        hold_nx  = hold_cnt;
        rpt_nx   = rpt_cnt;
        press_nx = 1'b0;
        rel_nx   = 1'b0;
        long_nx  = 1'b0;
        rpt_p_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                hold_nx = '0;
                rpt_nx  = '0;
                if (s) begin
                    if (deb_cnt == CN_M1) begin
                        state_nx = ST_HELD;
                        deb_nx   = '0;
                        press_nx = 1'b1;
                    end else begin
                        deb_nx = deb_cnt + 1'b1;
                    end
                end else begin
                    deb_nx = '0;
                end
            end
            ST_HELD, ST_RPT: begin
                if (!s) begin
                    if (deb_cnt == CN_M1) begin
                        state_nx = ST_IDLE;
                        deb_nx   = '0;
                        hold_nx  = '0;
                        rpt_nx   = '0;
                        rel_nx   = 1'b1;
                    end else begin
                        deb_nx = deb_cnt + 1'b1;
                    end
                end else begin
                    deb_nx = '0;
                    if (state == ST_HELD) begin
                        if (hold_cnt == LN_M1) begin
                            hold_nx  = LN_W;
                            rpt_nx   = '0;
                            state_nx = ST_RPT;
                            long_nx  = 1'b1;
                        end else begin
                            hold_nx = hold_cnt + 1'b1;
                        end
                    end else if (rpt_cnt == RN_M1) begin
                        rpt_nx   = '0;
                        rpt_p_nx = 1'b1;
                    end else begin
                        rpt_nx = rpt_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                deb_nx   = '0;
                hold_nx  = '0;
                rpt_nx   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: two instances (CN/LN/RN = 4/20/8 and 1/1/1)
// share one randomized key stream and are compared against a run-length model.
module tb_key_conditioner;

    typedef struct {
        int     hi;
        int     lo;
        int     held;
        bit     pressed;
        bit [1:0] hist;
    } mdl_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   edge_no;
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    mdl_t m0, m1;

    key_conditioner_if kif0 ();
    key_conditioner_if kif1 ();

    key_conditioner #(.CN(4), .LN(20), .RN(8)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (kif0.d_i),
        .d_o     (kif0.d_o),
        .p_press (kif0.p_press),
        .p_rel   (kif0.p_rel),
        .p_long  (kif0.p_long),
        .p_rpt   (kif0.p_rpt)
    );

    key_conditioner #(.CN(1), .LN(1), .RN(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (kif1.d_i),
        .d_o     (kif1.d_o),
        .p_press (kif1.p_press),
        .p_rel   (kif1.p_rel),
        .p_long  (kif1.p_long),
        .p_rpt   (kif1.p_rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One model step per clock edge; s is the raw key as it was two edges earlier.
    // Result bits: {level, press, release, long, repeat}.
    function automatic logic [4:0] step(inout mdl_t m, input bit d,
                                        input int cn, input int ln, input int rn);
        bit s;
        logic [3:0] p;
        s = m.hist[1];
        p = '0;
        m.hist = {m.hist[0], d};
        if (!m.pressed) begin
            if (s) begin
                m.hi++;
                if (m.hi == cn) begin
                    m.pressed = 1'b1;
                    m.hi = 0;
                    m.lo = 0;
                    m.held = 0;
                    p[3] = 1'b1;
                end
            end else begin
                m.hi = 0;
            end
        end else if (!s) begin
            m.lo++;
            if (m.lo == cn) begin
                m.pressed = 1'b0;
                m.lo = 0;
                m.hi = 0;
                p[2] = 1'b1;
            end
        end else begin
            m.lo = 0;
            m.held++;
            if (m.held == ln) p[1] = 1'b1;
            else if (m.held > ln && ((m.held - ln) % rn) == 0) p[0] = 1'b1;
        end
        return {m.pressed, p};
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.hi = 0;
        m.lo = 0;
        m.held = 0;
        m.pressed = 1'b0;
        m.hist = 2'b00;
        return m;
    endfunction

    function automatic logic [4:0] out0();
        return {kif0.d_o, kif0.p_press, kif0.p_rel, kif0.p_long, kif0.p_rpt};
    endfunction

    function automatic logic [4:0] out1();
        return {kif1.d_o, kif1.p_press, kif1.p_rel, kif1.p_long, kif1.p_rpt};
    endfunction

    // Drive one edge's worth of stimulus and queue what each DUT must show after it.
    task automatic cycle(input bit d, input bit rst);
        bit was_running;
        @(negedge clk);
        was_running = rst_n;
        kif0.d_i = d;
        kif1.d_i = d;
        rst_n = rst;
        if (!rst) begin
            m0 = mdl_reset();
            m1 = mdl_reset();
            q0.push_back(5'b0);
            q1.push_back(5'b0);
            if (was_running) begin
                #1;
                vectors += 2;
                if (out0() !== 5'b0) begin
                    miscompares++;
                    $display("FAIL async_reset dut0: got %b want 00000", out0());
                end
                if (out1() !== 5'b0) begin
                    miscompares++;
                    $display("FAIL async_reset dut1: got %b want 00000", out1());
                end
            end
        end else begin
            q0.push_back(step(m0, d, 4, 20, 8));
            q1.push_back(step(m1, d, 1, 1, 1));
        end
    endtask

    task automatic run(input bit d, input int n);
        for (int i = 0; i < n; i++) cycle(d, 1'b1);
    endtask

    // Monitor: after every edge, pop the expectation for each DUT and compare.
    initial begin
        logic [4:0] e;
        edge_no = 0;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                vectors++;
                if (out0() !== e) begin
                    miscompares++;
                    $display("FAIL dut0_outputs edge %0d: got %b want %b", edge_no, out0(), e);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                vectors++;
                if (out1() !== e) begin
                    miscompares++;
                    $display("FAIL dut1_outputs edge %0d: got %b want %b", edge_no, out1(), e);
                end
            end
        end
    end

    initial begin
        int len;
        bit lvl;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        kif0.d_i = 1'b0;
        kif1.d_i = 1'b0;
        m0 = mdl_reset();
        m1 = mdl_reset();

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

        // Long hold into auto-repeat, then release from repeat.
        run(1'b1, 60);
        run(1'b0, 10);
        // Short bounce that must not register.
        run(1'b1, 3);
        run(1'b0, 10);
        // Low glitch while held delays the long press.
        run(1'b1, 12);
        run(1'b0, 3);
        run(1'b1, 30);
        run(1'b0, 10);
        // Reset in the middle of auto-repeat with the key still down.
        run(1'b1, 40);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        run(1'b1, 12);
        run(1'b0, 10);

        // Random key runs with occasional resets.
        lvl = 1'b0;
        for (int k = 0; k < 300; k++) begin
            lvl = ~lvl;
            len = (($urandom % 4) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                if (($urandom % 400) == 0) cycle(lvl, 1'b0);
                else cycle(lvl, 1'b1);
            end
        end
        run(1'b0, 10);

        @(posedge clk);
        #2;
        vectors++;
        if (q0.size() + q1.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending want 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
